// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit/receive FSM state encodings and the default bit period.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 10416;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; a write into a full FIFO is dropped and flagged.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     i_Clock,
  input  logic                     i_Rst_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  // Fullness is judged before any same-edge pop, so a write into a full FIFO is always lost.
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a bit-serialising FSM.
//
// state   | meaning
// IDLE    | line high, counters clear; pops the FIFO head when one is queued
// START   | start bit, line low for CLKS_PER_BIT cycles
// DATA    | eight data bits, LSB first, CLKS_PER_BIT cycles each
// STOP    | stop bit, line high; o_Tx_Done on its last cycle
// CLEANUP | one idle-high cycle before returning to IDLE
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_n,
  input  logic                          i_Tx_DV,
  input  logic [7:0]                    i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Overflow,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t      state, state_n;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             tx_serial_n;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_data;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_Clock   (i_Clock),
    .i_Rst_n   (i_Rst_n),
    .push      (i_Tx_DV),
    .push_data (i_Tx_Byte),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (o_Fifo_Count),
    .overflow  (o_Tx_Overflow)
  );

  assign o_Tx_Ready  = !fifo_full;
  assign o_Tx_Active = (state == START) || (state == DATA) || (state == STOP);
  assign o_Tx_Done   = (state == STOP) && (clk_cnt == CNT_LAST);

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_Tx_Serial <= 1'b1;
    end else begin
      state       <= state_n;
      clk_cnt     <= clk_cnt_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      o_Tx_Serial <= tx_serial_n;
    end
  end

  // The line level is computed for the state being entered, so o_Tx_Serial is a plain flop.
  always_comb begin
    state_n     = state;
    clk_cnt_n   = clk_cnt;
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    tx_serial_n = 1'b1;
    fifo_pop    = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_n = '0;
        bit_idx_n = '0;
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          shift_n     = fifo_data;
          state_n     = START;
          tx_serial_n = 1'b0;
        end
      end
      START: begin
        tx_serial_n = 1'b0;
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n   = '0;
          state_n     = DATA;
          tx_serial_n = shift[0];
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        tx_serial_n = shift[0];
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n     = STOP;
            tx_serial_n = 1'b1;
          end else begin
            bit_idx_n   = bit_idx + 1'b1;
            shift_n     = {1'b0, shift[7:1]};
            tx_serial_n = shift[1];
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n = '0;
          state_n   = CLEANUP;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      CLEANUP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: vector table, scoreboard-driven serial monitor, corner sequences.
module tb_uart_tx_buffered;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, ovf, serial, active, done;
  logic [3:0] count;

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock       (clk),
    .i_Rst_n       (rst_n),
    .i_Tx_DV       (dv),
    .i_Tx_Byte     (data),
    .o_Tx_Ready    (ready),
    .o_Tx_Overflow (ovf),
    .o_Tx_Serial   (serial),
    .o_Tx_Active   (active),
    .o_Tx_Done     (done),
    .o_Fifo_Count  (count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];
  int cyc = 0;
  int done_pulses = 0;
  int ovf_pulses = 0;
  int frames = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Serial monitor: checks every cycle of each frame against the scoreboard head and decodes it.
  logic       mon_busy = 1'b0;
  int         mon_cyc = 0;
  int         mon_bad = 0;
  int         mon_done_bad = 0;
  logic [7:0] mon_exp = 8'h00;
  logic [7:0] mon_rx = 8'h00;
  logic       mon_valid = 1'b0;
  logic       gap_pending = 1'b0;
  int         last_done_cyc = 0;
  int         mk;
  logic       mbit;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_busy    = 1'b0;
      gap_pending = 1'b0;
    end else begin
      if (done) done_pulses++;
      if (ovf)  ovf_pulses++;
      if (!mon_busy && serial === 1'b0) begin
        mon_busy     = 1'b1;
        mon_cyc      = 0;
        mon_bad      = 0;
        mon_done_bad = 0;
        check("frame_expected", int'(sb.size() > 0), 1);
        mon_valid = (sb.size() > 0);
        mon_exp   = mon_valid ? sb[0] : 8'h00;
        if (gap_pending) begin
          check("frame_gap", cyc - last_done_cyc, 3);
          gap_pending = 1'b0;
        end
      end else if (mon_busy) begin
        mon_cyc++;
      end
      if (mon_busy) begin
        mk = mon_cyc / CPB;
        if (mk == 0)      mbit = 1'b0;
        else if (mk == 9) mbit = 1'b1;
        else              mbit = mon_exp[mk-1];
        if (serial !== mbit || active !== 1'b1) mon_bad++;
        if (done !== (mon_cyc == FRAME - 1)) mon_done_bad++;
        if (mk >= 1 && mk <= 8 && (mon_cyc % CPB) == CPB / 2) mon_rx[mk-1] = serial;
        if (mon_cyc == FRAME - 1) begin
          check("frame_wave", mon_bad, 0);
          check("done_pos", mon_done_bad, 0);
          if (mon_valid) begin
            check("rx_byte", int'(mon_rx), int'(mon_exp));
            gap_pending   = (sb.size() > 1);
            last_done_cyc = cyc;
            void'(sb.pop_front());
          end
          frames++;
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    repeat (5) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    int         exp_cnt;
    logic       exp_ready;
    logic       exp_ovf;
    logic       acc;
  } vec_t;

  vec_t tbl[10];
  int   exp_cnts[10] = '{1, 1, 2, 3, 4, 5, 6, 7, 8, 8};
  logic [7:0] lb[3] = '{8'h00, 8'hFF, 8'h3C};

  initial begin
    int n;
    int low_cycles;
    int act_cycles;
    int done_before;
    int frames_before;

    for (int i = 0; i < 10; i++) begin
      tbl[i].data      = 8'h40 + 8'(i * 7);
      tbl[i].exp_cnt   = exp_cnts[i];
      tbl[i].exp_ready = (i < 8);
      tbl[i].exp_ovf   = (i == 9);
      tbl[i].acc       = (i != 9);
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_serial", int'(serial), 1);
    check("rst_active", int'(active), 0);
    check("rst_done", int'(done), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_count", int'(count), 0);
    check("rst_ready", int'(ready), 1);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_no_frame", frames, 0);
    check("idle_line", int'(serial), 1);

    // Single 0xA5 with exact first-frame latency
    dv = 1'b1; data = 8'hA5; sb.push_back(8'hA5);
    @(negedge clk);
    dv = 1'b0;
    check("a5_count_after_write", int'(count), 1);
    check("a5_line_before_start", int'(serial), 1);
    @(negedge clk);
    check("a5_start_low", int'(serial), 0);
    check("a5_active", int'(active), 1);
    check("a5_count_popped", int'(count), 0);
    wait_drain(FRAME + 50);
    check("a5_frames", frames, 1);
    check("a5_done_pulses", done_pulses, 1);
    check("a5_idle_after", int'(active), 0);

    // Back-to-back loopback bytes
    for (int i = 0; i < 3; i++) begin
      dv = 1'b1; data = lb[i]; sb.push_back(lb[i]);
      @(negedge clk);
    end
    dv = 1'b0;
    wait_drain(3 * (FRAME + 2) + 50);
    check("lb_frames", frames, 4);

    // Ten consecutive writes from idle: 1 in flight, 8 queued, 1 dropped
    for (int i = 0; i < 10; i++) begin
      dv = 1'b1; data = tbl[i].data;
      if (tbl[i].acc) sb.push_back(tbl[i].data);
      @(negedge clk);
      check($sformatf("burst%0d_count", i), int'(count), tbl[i].exp_cnt);
      check($sformatf("burst%0d_ready", i), int'(ready), int'(tbl[i].exp_ready));
      check($sformatf("burst%0d_ovf", i), int'(ovf), int'(tbl[i].exp_ovf));
    end
    dv = 1'b0;
    @(negedge clk);
    check("burst_ovf_single", int'(ovf), 0);

    // Full FIFO with a push on the same edge as the FSM pop
    n = 0;
    while (!done && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("full_wait_done", int'(done), 1);
    check("full_before_pop", int'(count), 8);
    @(negedge clk);
    @(negedge clk);
    dv = 1'b1; data = 8'hEE;
    @(negedge clk);
    dv = 1'b0;
    check("full_pop_count", int'(count), 7);
    check("full_pop_ovf", int'(ovf), 1);
    wait_drain(9 * (FRAME + 2) + 100);
    check("burst_frames", frames, 13);
    check("burst_done_pulses", done_pulses, 13);
    check("ovf_pulses", ovf_pulses, 2);

    // Reset during DATA bit 3
    foreach (lb[i]) begin
      dv = 1'b1; data = (i == 0) ? 8'hA5 : lb[i]; sb.push_back(data);
      @(negedge clk);
    end
    dv = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(mon_busy && mon_cyc == CPB + 3 * CPB + 6) && n < 200);
    check("rst_mid_reached", int'(mon_busy && mon_cyc == CPB + 3 * CPB + 6), 1);
    check("rst_mid_pre_low", int'(serial), 0);
    done_before   = done_pulses;
    frames_before = frames;
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_line", int'(serial), 1);
    check("rst_mid_count", int'(count), 0);
    check("rst_mid_active", int'(active), 0);
    check("rst_mid_done", int'(done), 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    low_cycles = 0;
    act_cycles = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (!serial) low_cycles++;
      if (active) act_cycles++;
    end
    check("post_rst_line_low", low_cycles, 0);
    check("post_rst_active", act_cycles, 0);
    check("post_rst_done", done_pulses, done_before);
    check("post_rst_frames", frames, frames_before);

    // A new write after reset starts a fresh frame
    dv = 1'b1; data = 8'h96; sb.push_back(8'h96);
    @(negedge clk);
    dv = 1'b0;
    wait_drain(FRAME + 50);
    check("post_rst_new_frame", frames, frames_before + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10416, clock cycles per serial bit (100 MHz at 9600 baud); the block SHALL support any value >= 4.
REQ-002 Parameter FIFO_DEPTH, default 8, number of byte entries in the transmit FIFO; the block SHALL require a power of 2 >= 2.
REQ-003 i_Clock  input  1  system clock; all state SHALL change on its rising edge.
REQ-004 i_Rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 i_Tx_DV  input  1  write strobe; i_Tx_Byte is sampled on each rising edge where this is high.
REQ-006 i_Tx_Byte  input  8  byte to enqueue.
REQ-007 o_Tx_Ready  output  1  high when the FIFO is not full.
REQ-008 o_Tx_Overflow  output  1  one-cycle pulse when a write is dropped.
REQ-009 o_Tx_Serial  output  1  serial line; idle high; 8N1 framing, LSB first.
REQ-010 o_Tx_Active  output  1  high from start-bit entry until stop-bit completion.
REQ-011 o_Tx_Done  output  1  one-cycle pulse at the end of each stop bit.
REQ-012 o_Fifo_Count  output  clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte in flight.

Function
REQ-013 A write with i_Tx_DV=1 and FIFO not full SHALL enqueue i_Tx_Byte, and o_Fifo_Count SHALL increment on the same edge.
REQ-014 A write with the FIFO full SHALL be dropped, even if a pop occurs on the same edge; o_Tx_Overflow SHALL pulse on the next cycle.
REQ-015 o_Tx_Ready SHALL be combinational from the FIFO count: high iff count < FIFO_DEPTH.
REQ-016 The transmit FSM SHALL have states IDLE, START, DATA, STOP and CLEANUP.
REQ-017 IDLE: o_Tx_Serial=1, counters cleared; if the FIFO is non-empty, the block SHALL pop the head into an 8-bit shift register and enter START.
REQ-018 START: o_Tx_Serial=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-019 DATA: each bit SHALL be held for CLKS_PER_BIT cycles, bit 0 first; after bit index 7 the FSM SHALL enter STOP.
REQ-020 STOP: o_Tx_Serial=1 for CLKS_PER_BIT cycles; on the final cycle the FSM SHALL assert o_Tx_Done for one cycle and enter CLEANUP.
REQ-021 CLEANUP: one cycle with line high, then IDLE.
REQ-022 Back-to-back frames SHALL have exactly 2 extra idle-high cycles (CLEANUP plus IDLE) between the stop-bit end and the next start bit.
REQ-023 Latency: for a write on edge N into an empty FIFO with the FSM in IDLE, o_Tx_Serial SHALL go low after edge N+1.
REQ-024 The bit counter SHALL be clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary.
REQ-025 The bit index SHALL be 3 bits wide.
REQ-026 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 A simultaneous push and pop on a non-full FIFO SHALL leave the count unchanged and preserve data order.
REQ-028 o_Tx_Serial SHALL be driven from a flop, with no combinational glitches.
REQ-029 o_Tx_Active SHALL be high in START, DATA and STOP only.

Reset
REQ-030 While i_Rst_n=0: FSM=IDLE, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Overflow=0, FIFO emptied (o_Fifo_Count=0), o_Tx_Ready=1, all counters 0.
REQ-031 Reset mid-frame SHALL abort the frame immediately; the line SHALL return high asynchronously and no o_Tx_Done SHALL be generated.
REQ-032 The first frame after reset deassertion SHALL start only from a new write.

Structure
REQ-033 Shared package uart_pkg SHALL hold the state encodings (3-bit: IDLE=0, START=1, DATA=2, STOP=3, CLEANUP=4) and the default CLKS_PER_BIT constant, shared with the receiver.
REQ-034 The FIFO SHALL be a sub-module uart_tx_fifo (parameterised depth, 8-bit data, push/pop/full/empty/count); the FSM and shift register SHALL live in the top level.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=8)
REQ-035 Write 0xA5 from idle -> line low 16 cycles; bits 1,0,1,0,0,1,0,1 at 16 cycles each; high 16 cycles; o_Tx_Done pulses once; total frame 160 cycles.
REQ-036 Loopback into the team's uart_rx at the same CLKS_PER_BIT, writing 0x00, 0xFF, 0x3C back-to-back -> three o_Rx_DV pulses with bytes 0x00, 0xFF, 0x3C in order; inter-frame gap 2 cycles.
REQ-037 Write 10 bytes on consecutive cycles from idle -> first is popped into flight, next 8 fill the FIFO, o_Tx_Ready=0, 10th dropped with one o_Tx_Overflow pulse; exactly 9 frames are transmitted.
REQ-038 FIFO full plus a push on the same edge as the FSM pop -> push dropped, o_Fifo_Count goes 8 to 7, o_Tx_Overflow pulses.
REQ-039 Assert i_Rst_n=0 during DATA bit 3 -> o_Tx_Serial=1 with no clock edge, o_Fifo_Count=0, no o_Tx_Done; after release, line idle until the next write.
